// File: rtl/ext_int_source.sv
// ext_int_source: external interrupt generator for the mips system bench.
// A trigger raises `interrupt` after a programmable delay; the CPU clears it
// by writing ACK_ADDR through the bridge. Triggers arriving while busy queue
// up (up to 7) and replay with the most recent nonzero delay.
// Optional feature: define EXT_INT_TIMEOUT_EN to auto-release ASSERT after
// TIMEOUT cycles without an acknowledge (sets sticky timeout_err).
//
// state  | meaning
// IDLE   | nothing in flight, ready to accept a trigger
// WAIT   | counting down cnt before raising interrupt
// ASSERT | interrupt high, waiting for the acknowledge write
module ext_int_source #(
    parameter logic [31:0] ACK_ADDR = 32'h0000_7F20,
    parameter logic [15:0] TIMEOUT  = 16'd1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        trigger,
    input  logic [15:0] delay,
    input  logic [31:0] int_addr,
    input  logic [3:0]  int_byteen,
    output logic        interrupt,
    output logic        busy,
    output logic [2:0]  pending,
    output logic [15:0] ack_count,
    output logic        stray_ack,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ASSERT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] dly_reg;
    logic        ack;
    logic        pend_dec;
    logic        pend_inc;
    logic        count_ack;
    logic        tmo_hit;
    logic        unused_addr_bits;

    // Acknowledge decode: word-address match with any byte lane enabled.
    assign ack = (int_byteen != 4'b0000) && (int_addr[31:2] == ACK_ADDR[31:2]);
    assign unused_addr_bits = ^int_addr[1:0];

    // Triggers landing while a request is in flight go to the queue.
    assign pend_inc = trigger && (state_q != ST_IDLE);

    assign interrupt = (state_q == ST_ASSERT);
    assign busy      = (state_q != ST_IDLE);

`ifdef EXT_INT_TIMEOUT_EN
    logic [15:0] tmo_q;

    assign tmo_hit = (state_q == ST_ASSERT) && ((tmo_q + 16'd1) == TIMEOUT);

    // Cycle count since entering ASSERT; restarts on every fresh entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_q <= 16'd0;
        end else if (state_q != ST_ASSERT) begin
            tmo_q <= 16'd0;
        end else begin
            tmo_q <= tmo_q + 16'd1;
        end
    end

    // Sticky flag: ASSERT released by the timer rather than by an ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_err <= 1'b0;
        end else if (tmo_hit && !ack) begin
            timeout_err <= 1'b1;
        end
    end
`else
    assign tmo_hit     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Next-state and countdown decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_dec  = 1'b0;
        count_ack = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    state_d = ST_WAIT;
                    cnt_d   = delay;
                end else if (pending != 3'd0) begin
                    state_d  = ST_WAIT;
                    cnt_d    = dly_reg;
                    pend_dec = 1'b1;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 16'd0) begin
                    state_d = ST_ASSERT;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_ASSERT: begin
                count_ack = ack;
                if (ack || tmo_hit) begin
                    if (pending != 3'd0) begin
                        state_d  = ST_WAIT;
                        cnt_d    = dly_reg;
                        pend_dec = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register and countdown.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Replay delay: only a nonzero delay replaces the stored value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dly_reg <= 16'd0;
        end else if (trigger && (delay != 16'd0)) begin
            dly_reg <= delay;
        end
    end

    // Queue depth: a same-edge enqueue and dequeue cancel out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= 3'd0;
        end else if (pend_dec && pend_inc) begin
            pending <= pending;
        end else if (pend_dec) begin
            pending <= pending - 3'd1;
        end else if (pend_inc && (pending != 3'd7)) begin
            pending <= pending + 3'd1;
        end
    end

    // Accepted-acknowledge counter (wraps) and sticky stray-ack flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_count <= 16'd0;
            stray_ack <= 1'b0;
        end else begin
            if (count_ack) begin
                ack_count <= ack_count + 16'd1;
            end
            if (ack && (state_q != ST_ASSERT)) begin
                stray_ack <= 1'b1;
            end
        end
    end

endmodule
